// File: rtl/cpu_controller.sv
// Control unit for the 16-bit CPU: owns PC and IR, sequences fetch,
// and decodes the current state and IR into datapath control signals.
module cpu_controller #(
  parameter int PC_W = 7
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic [15:0]     I_Data,
  output logic [PC_W-1:0] I_Addr,
  output logic [7:0]      D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_Addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [15:0]     IR_Out,
  output logic [3:0]      State_Out,
  output logic            Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_DECODE = 4'd3,
    S_NOOP   = 4'd4,
    S_STORE  = 4'd5,
    S_LOAD_A = 4'd6,
    S_LOAD_B = 4'd7,
    S_ADD    = 4'd8,
    S_SUB    = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_DECODE;
        ir_d    = I_Data;
        pc_d    = pc_q + PC_W'(1);
      end
      S_DECODE: begin
        case (ir_q[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP,
      S_STORE,
      S_LOAD_B,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Moore decode: every control output depends only on state and IR.
  always_comb begin
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = 3'b000;
    unique case (state_q)
      S_STORE: begin
        D_Addr     = ir_q[11:4];
        RF_Ra_Addr = ir_q[3:0];
        D_Wr       = 1'b1;
      end
      S_LOAD_A: D_Addr = ir_q[11:4];
      S_LOAD_B: begin
        D_Addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[3:0];
        RF_W_en   = 1'b1;
      end
      S_ADD,
      S_SUB: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

  assign I_Addr    = pc_q;
  assign IR_Out    = ir_q;
  assign State_Out = state_q;
  assign Halted    = (state_q == S_HALT);

endmodule
